// File: rtl/ysyx_23060337_exec_ctrl.sv
// Multi-cycle execution controller: sequences fetch/decode/execute/memory/writeback
// over ready/valid memory handshakes, with a watchdog that halts on stalled transfers.
module ysyx_23060337_exec_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        ebreak,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic        dmem_req_ready,
    input  logic        dmem_resp_valid,
    output logic        imem_req_valid,
    output logic        inst_we,
    output logic        dmem_req_valid,
    output logic        dmem_we,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        halted,
    output logic        err,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_IWAIT  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_MWAIT  = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t            r_state;
    logic [6:0]        r_op_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_instret;
    logic              r_err;

    logic              w_waiting;
    logic              w_hs_done;
    state_t            w_hs_next;
    logic              w_legal;
    logic              w_timeout;
    logic              w_no_rf;

    // Handshake states share one watchdog path; only the completing signal differs.
    always_comb begin
        w_waiting = 1'b0;
        w_hs_done = 1'b0;
        w_hs_next = r_state;
        case (r_state)
            S_FETCH: begin
                w_waiting = 1'b1;
                w_hs_done = imem_req_ready;
                w_hs_next = S_IWAIT;
            end
            S_IWAIT: begin
                w_waiting = 1'b1;
                w_hs_done = imem_resp_valid;
                w_hs_next = S_DECODE;
            end
            S_MEM: begin
                w_waiting = 1'b1;
                w_hs_done = dmem_req_ready;
                w_hs_next = S_MWAIT;
            end
            S_MWAIT: begin
                w_waiting = 1'b1;
                w_hs_done = dmem_resp_valid;
                w_hs_next = S_WB;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM: w_legal = 1'b1;
            default:                                      w_legal = 1'b0;
        endcase
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_op_q    <= '0;
            r_cnt     <= '0;
            r_instret <= '0;
            r_err     <= 1'b0;
        end else if (w_waiting) begin
            // A handshake landing on the last allowed cycle still counts as success.
            if (w_hs_done) begin
                r_state <= w_hs_next;
                r_cnt   <= '0;
            end else if (w_timeout) begin
                r_state <= S_HALT;
                r_err   <= 1'b1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
            case (r_state)
                S_DECODE: begin
                    r_op_q <= opcode;
                    if (!w_legal) begin
                        r_state <= S_HALT;
                        r_err   <= 1'b1;
                    end else if (opcode == OP_SYSTEM && ebreak) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= (r_op_q == OP_LOAD || r_op_q == OP_STORE) ? S_MEM : S_WB;
                end
                S_WB: begin
                    r_instret <= r_instret + 32'd1;
                    r_state   <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

    // Stores, branches and system ops retire without a register write.
    assign w_no_rf = (r_op_q == OP_STORE) || (r_op_q == OP_BRANCH) || (r_op_q == OP_SYSTEM);

    assign imem_req_valid = (r_state == S_FETCH);
    assign inst_we        = (r_state == S_IWAIT) && imem_resp_valid;
    assign dmem_req_valid = (r_state == S_MEM);
    assign dmem_we        = (r_state == S_MEM) && (r_op_q == OP_STORE);
    assign pc_wen         = (r_state == S_WB);
    assign rf_wen         = (r_state == S_WB) && !w_no_rf;
    assign halted         = (r_state == S_HALT);
    assign err            = r_err;
    assign state          = r_state;
    assign instret        = r_instret;

endmodule

// File: tb/tb_ysyx_23060337_exec_ctrl.sv
// Directed bench for the execution controller: per-cycle reference model plus
// hand-computed latency/strobe expectations for the key scenarios.
module tb_ysyx_23060337_exec_ctrl;

    localparam int TIMEOUT = 255;
    localparam logic [6:0] ADDI   = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] SYS    = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode = '0;
    logic        ebreak = 1'b0;
    logic        imem_req_ready = 1'b0, imem_resp_valid = 1'b0;
    logic        dmem_req_ready = 1'b0, dmem_resp_valid = 1'b0;
    logic        imem_req_valid, inst_we, dmem_req_valid, dmem_we;
    logic        rf_wen, pc_wen, halted, err;
    logic [2:0]  state;
    logic [31:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] legal_ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                   7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};

    ysyx_23060337_exec_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .ebreak(ebreak),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_resp_valid(dmem_resp_valid),
        .imem_req_valid(imem_req_valid), .inst_we(inst_we),
        .dmem_req_valid(dmem_req_valid), .dmem_we(dmem_we),
        .rf_wen(rf_wen), .pc_wen(pc_wen), .halted(halted), .err(err),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase numbers follow the architectural state list,
    // m_wait = cycles already spent in the current waiting phase.
    int          m_ph = 0;
    int          m_wait = 0;
    logic [6:0]  m_op = '0;
    logic [31:0] m_ret = '0;
    logic        m_err = 1'b0;

    function automatic logic hs_ok(input int ph);
        case (ph)
            0: return imem_req_ready;
            1: return imem_resp_valid;
            4: return dmem_req_ready;
            default: return dmem_resp_valid;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph <= 0; m_wait <= 0; m_op <= '0; m_ret <= '0; m_err <= 1'b0;
        end else begin
            case (m_ph)
                0, 1, 4, 5: begin
                    if (hs_ok(m_ph)) begin
                        m_ph   <= m_ph + 1;
                        m_wait <= 0;
                    end else if (m_wait >= TIMEOUT) begin
                        m_ph  <= 7;
                        m_err <= 1'b1;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
                2: begin
                    m_op <= opcode;
                    if (!(opcode inside {legal_ops})) begin
                        m_ph <= 7; m_err <= 1'b1;
                    end else if (opcode == SYS && ebreak) m_ph <= 7;
                    else m_ph <= 3;
                end
                3: m_ph <= (m_op == LOAD || m_op == STORE) ? 4 : 6;
                6: begin m_ret <= m_ret + 32'd1; m_ph <= 0; end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("state", 32'(state), 32'(m_ph));
        chk("instret", instret, m_ret);
        chkb("err", err, m_err);
        chkb("halted", halted, m_ph == 7);
        chkb("imem_req_valid", imem_req_valid, m_ph == 0);
        chkb("inst_we", inst_we, m_ph == 1 && imem_resp_valid);
        chkb("dmem_req_valid", dmem_req_valid, m_ph == 4);
        chkb("dmem_we", dmem_we, m_ph == 4 && m_op == STORE);
        chkb("pc_wen", pc_wen, m_ph == 6);
        chkb("rf_wen", rf_wen, m_ph == 6 && !(m_op inside {STORE, BRANCH, SYS}));
        chkb("one_req", (int'(imem_req_valid) + int'(dmem_req_valid) + int'(pc_wen)) <= 1, 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic set_hs(input logic ir, input logic iv, input logic dr, input logic dv);
        imem_req_ready = ir; imem_resp_valid = iv; dmem_req_ready = dr; dmem_resp_valid = dv;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int st [1:6];
        int iwe_c, wb_c, cyc, mc, wc, fc, strobes;
        logic wb_rf, seen;

        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chkb("rst_halted", halted, 1'b0);
        chkb("rst_err", err, 1'b0);
        chkb("rst_strobes", inst_we | dmem_req_valid | rf_wen | pc_wen, 1'b0);

        // ADDI with every handshake tied high
        opcode = ADDI; set_hs(1, 1, 1, 1);
        do_reset();
        iwe_c = 0; wb_c = 0; wb_rf = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            st[c] = int'(state);
            if (inst_we) iwe_c = c;
            if (pc_wen) begin wb_c = c; wb_rf = rf_wen; end
        end
        chk("addi_s1", 32'(st[1]), 32'd0);
        chk("addi_s2", 32'(st[2]), 32'd1);
        chk("addi_s3", 32'(st[3]), 32'd2);
        chk("addi_s4", 32'(st[4]), 32'd3);
        chk("addi_s5", 32'(st[5]), 32'd6);
        chk("addi_s6", 32'(st[6]), 32'd0);
        chk("addi_iwe_cycle", 32'(iwe_c), 32'd2);
        chk("addi_wb_cycle", 32'(wb_c), 32'd5);
        chkb("addi_rf_wen", wb_rf, 1'b1);
        chk("addi_instret", instret, 32'd1);
        imem_req_ready = 0;

        // Store with the data request accepted on its fourth cycle
        opcode = STORE; set_hs(1, 1, 0, 1);
        do_reset();
        mc = 0; wc = 0; seen = 0; wb_rf = 1; cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (dmem_req_valid) begin
                mc++;
                if (dmem_we) wc++;
                dmem_req_ready = (mc >= 4);
            end
            if (pc_wen) begin seen = 1; wb_rf = rf_wen; cyc = c; break; end
        end
        imem_req_ready = 0; dmem_req_ready = 0;
        chkb("store_wb_seen", seen, 1'b1);
        chk("store_req_cycles", 32'(mc), 32'd4);
        chk("store_we_cycles", 32'(wc), 32'd4);
        chkb("store_rf_wen", wb_rf, 1'b0);
        chk("store_wb_cycle", 32'(cyc), 32'd10);

        // Illegal opcode halts with error; halted core ignores everything
        opcode = 7'h7f; set_hs(1, 1, 1, 1);
        do_reset();
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (halted) begin cyc = c; break; end
        end
        chk("illegal_halt_cycle", 32'(cyc), 32'd4);
        chkb("illegal_err", err, 1'b1);
        chk("illegal_state", 32'(state), 32'd7);
        strobes = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            set_hs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            opcode = 7'($urandom_range(0, 127));
            @(negedge clk);
            strobes += int'(imem_req_valid) + int'(inst_we) + int'(dmem_req_valid)
                     + int'(dmem_we) + int'(rf_wen) + int'(pc_wen);
        end
        chk("halt_strobes", 32'(strobes), 32'd0);
        chkb("halt_sticky", halted, 1'b1);

        // Fetch never accepted: watchdog fires after TIMEOUT+1 cycles
        set_hs(0, 0, 0, 0); opcode = ADDI;
        do_reset();
        fc = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (state == 3'd0) fc++; else break;
        end
        chk("wd_fetch_cycles", 32'(fc), 32'd256);
        chk("wd_state", 32'(state), 32'd7);
        chkb("wd_err", err, 1'b1);

        // Ready arrives on the last allowed cycle: handshake wins
        do_reset();
        fc = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (state == 3'd0) begin
                fc++;
                if (fc == 256) imem_req_ready = 1;
            end else break;
        end
        imem_req_ready = 0;
        chk("wd_edge_fetch_cycles", 32'(fc), 32'd256);
        chk("wd_edge_state", 32'(state), 32'd1);
        chkb("wd_edge_err", err, 1'b0);

        // Reset while waiting for a load response; late response ignored
        opcode = ADDI; set_hs(1, 1, 1, 0);
        do_reset();
        for (int c = 0; c < 20 && instret != 32'd1; c++) @(negedge clk);
        chk("mw_pre_instret", instret, 32'd1);
        opcode = LOAD;
        for (int c = 0; c < 20 && state != 3'd5; c++) @(negedge clk);
        chk("mw_reached", 32'(state), 32'd5);
        #2 rst = 1'b0;
        #1;
        chk("mw_rst_state", 32'(state), 32'd0);
        chk("mw_rst_instret", instret, 32'd0);
        chkb("mw_rst_err", err, 1'b0);
        set_hs(0, 0, 0, 0);
        tick();
        rst = 1'b1;
        dmem_resp_valid = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mw_late_state", 32'(state), 32'd0);
            chk("mw_late_instret", instret, 32'd0);
        end
        dmem_resp_valid = 0;

        // EBREAK halts cleanly
        opcode = SYS; ebreak = 1; set_hs(1, 1, 1, 1);
        do_reset();
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (halted) begin cyc = c; break; end
        end
        chk("ebreak_halt_cycle", 32'(cyc), 32'd4);
        chkb("ebreak_err", err, 1'b0);
        chk("ebreak_instret", instret, 32'd0);

        // Other SYSTEM ops retire without a register write
        ebreak = 0;
        do_reset();
        cyc = 0; wb_rf = 1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (pc_wen) begin cyc = c; wb_rf = rf_wen; break; end
        end
        chk("ecall_wb_cycle", 32'(cyc), 32'd5);
        chkb("ecall_rf_wen", wb_rf, 1'b0);

        // Mixed legal instructions under random handshake timing
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            opcode = legal_ops[$urandom_range(0, 9)];
            set_hs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        chkb("mix_progress", instret != 32'd0, 1'b1);
        chkb("mix_no_halt", halted, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
